// File: rtl/memory_unit.sv
// Word-addressed 32-bit data memory responding to MAR/MDR strobes after WAIT_CYCLES wait states.
// Completion is signalled on MFC with a four-phase handshake; read data is registered on Mdatain.
module memory_unit #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       Mdatain,
  output logic              MFC,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              op_wr_q;
  logic              accept;
  logic              perform;
  logic              op_strobe;
  logic [31:0]       mem [DEPTH];

  // Simultaneous read and write is an illegal request and is never accepted.
  assign accept    = (state == S_IDLE) && (read ^ write);
  assign perform   = (state == S_WAIT) && (cnt == 4'd0);
  assign op_strobe = op_wr_q ? write : read;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_WAIT;
          cnt_nxt   = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_DONE: begin
        if (!op_strobe) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      MFC     <= 1'b0;
      Mdatain <= 32'h0;
      addr_q  <= '0;
      data_q  <= 32'h0;
      op_wr_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      MFC   <= (state_nxt == S_DONE);
      if (accept) begin
        addr_q  <= address;
        data_q  <= data_in;
        op_wr_q <= write;
      end
      if (perform && !op_wr_q) begin
        Mdatain <= mem[addr_q];
      end
    end
  end

  // Storage has no reset; reset forces IDLE so an aborted write never gets here.
  always_ff @(posedge clk) begin
    if (perform && op_wr_q) begin
      mem[addr_q] <= data_q;
    end
  end

endmodule
